// File: rtl/pulse_swallow_pkg.sv
// Shared types and helpers for the pulse-swallow modulus controller.
//
// Contents:
//   PscCntW   - default width of the P/S counters and config fields
//   PscNW     - width of the division ratio N = 3P + S
//   ratio_n   - computes 3p + s at full width (no overflow)
//   cfg_valid - a (p, s) pair is usable when p >= 1 and s <= p
//
// The helper functions are sized by PscCntW, so the modules that use them
// keep CNT_W at this default.
package pulse_swallow_pkg;

  localparam int unsigned PscCntW = 6;
  localparam int unsigned PscNW   = PscCntW + 2;

  // Max result is 4 * (2^PscCntW - 1), which fits in PscCntW + 2 bits.
  function automatic logic [PscNW-1:0] ratio_n(input logic [PscCntW-1:0] p,
                                               input logic [PscCntW-1:0] s);
    logic [PscNW-1:0] pw;
    logic [PscNW-1:0] sw;
    pw = {2'b00, p};
    sw = {2'b00, s};
    return (pw << 1) + pw + sw;
  endfunction

  function automatic logic cfg_valid(input logic [PscCntW-1:0] p,
                                     input logic [PscCntW-1:0] s);
    return (p != '0) && (s <= p);
  endfunction

endpackage

// File: rtl/ps_cfg_shadow.sv
// Shadow configuration for the pulse-swallow controller.
//
// Captures a requested (P, S) pair on cfg_load_i, validates it and holds it
// until the counter reports a period boundary (wrap_i). apply_o then tells the
// top to copy p_sh_o/s_sh_o into the active config on that same edge.
//
// Ports:
//   clk_i       clock (prescaler output)
//   rst_i       synchronous active-high reset
//   cfg_load_i  one-cycle load strobe
//   cfg_p_i     requested P
//   cfg_s_i     requested S
//   wrap_i      the current edge ends an output period
//   apply_o     combinational: active config takes the shadow on this edge
//   p_sh_o      shadow P
//   s_sh_o      shadow S
//   pend_o      a valid config is waiting for the next boundary
//   err_o       one-cycle pulse after a rejected load
module ps_cfg_shadow
  import pulse_swallow_pkg::*;
#(
  parameter int unsigned CNT_W = PscCntW,
  parameter int unsigned P_DEF = 4,
  parameter int unsigned S_DEF = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_load_i,
  input  logic [CNT_W-1:0] cfg_p_i,
  input  logic [CNT_W-1:0] cfg_s_i,
  input  logic             wrap_i,
  output logic             apply_o,
  output logic [CNT_W-1:0] p_sh_o,
  output logic [CNT_W-1:0] s_sh_o,
  output logic             pend_o,
  output logic             err_o
);

  logic [CNT_W-1:0] p_sh_q, p_sh_d;
  logic [CNT_W-1:0] s_sh_q, s_sh_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             load_ok;

  assign load_ok = cfg_load_i && cfg_valid(cfg_p_i, cfg_s_i);

  // A valid load landing on the boundary edge supersedes the older pending
  // value: that value is dropped and the new one waits for the next boundary.
  assign apply_o = wrap_i && pend_q && !load_ok;

  always_comb begin
    p_sh_d = p_sh_q;
    s_sh_d = s_sh_q;
    pend_d = pend_q;
    err_d  = cfg_load_i && !load_ok;
    if (load_ok) begin
      p_sh_d = cfg_p_i;
      s_sh_d = cfg_s_i;
      pend_d = 1'b1;
    end else if (wrap_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_sh_q <= CNT_W'(P_DEF);
      s_sh_q <= CNT_W'(S_DEF);
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      p_sh_q <= p_sh_d;
      s_sh_q <= s_sh_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign p_sh_o = p_sh_q;
  assign s_sh_o = s_sh_q;
  assign pend_o = pend_q;
  assign err_o  = err_q;

endmodule

// File: rtl/pulse_swallow_ctrl.sv
// Modulus controller for a dual-modulus /3 / /4 prescaler.
//
// Counts P prescaler periods per output period and holds mod_o high (/4) for
// the first S of them, giving N = 3P + S. New configs are double-buffered in
// ps_cfg_shadow and only applied on a period boundary.
//
// Optional build macro PSC_TOGGLE_OUT_EN adds div_tgl_o, a flop toggling on
// every boundary (~50% duty output at ratio 2N).
//
// Ports:
//   clk_in_i    prescaler output clock
//   rst_i       synchronous active-high reset
//   en_i        count enable; low holds all counting state
//   cfg_load_i  one-cycle strobe capturing cfg_p_i/cfg_s_i
//   cfg_p_i     requested P
//   cfg_s_i     requested S
//   mod_o       modulus select (1 = /4), decoded from registered state
//   div_out_o   one-cycle pulse per completed output period
//   cfg_pend_o  accepted config waiting for the next boundary
//   cfg_err_o   one-cycle pulse: load rejected
//   n_act_o     active ratio 3P + S
//   div_tgl_o   (PSC_TOGGLE_OUT_EN only) toggles on every boundary
module pulse_swallow_ctrl
  import pulse_swallow_pkg::*;
#(
  parameter int unsigned CNT_W = PscCntW,
  parameter int unsigned P_DEF = 4,
  parameter int unsigned S_DEF = 0
) (
  input  logic             clk_in_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cfg_load_i,
  input  logic [CNT_W-1:0] cfg_p_i,
  input  logic [CNT_W-1:0] cfg_s_i,
  output logic             mod_o,
  output logic             div_out_o,
  output logic             cfg_pend_o,
  output logic             cfg_err_o,
`ifdef PSC_TOGGLE_OUT_EN
  output logic             div_tgl_o,
`endif
  output logic [CNT_W+1:0] n_act_o
);

  logic [CNT_W-1:0] pc_q;
  logic [CNT_W-1:0] p_act_q;
  logic [CNT_W-1:0] s_act_q;
  logic [CNT_W+1:0] n_act_q;
  logic             div_q;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] p_sh;
  logic [CNT_W-1:0] s_sh;

  assign wrap = en_i && (pc_q == p_act_q - CNT_W'(1));

  ps_cfg_shadow #(
    .CNT_W (CNT_W),
    .P_DEF (P_DEF),
    .S_DEF (S_DEF)
  ) u_cfg_shadow (
    .clk_i      (clk_in_i),
    .rst_i      (rst_i),
    .cfg_load_i (cfg_load_i),
    .cfg_p_i    (cfg_p_i),
    .cfg_s_i    (cfg_s_i),
    .wrap_i     (wrap),
    .apply_o    (apply),
    .p_sh_o     (p_sh),
    .s_sh_o     (s_sh),
    .pend_o     (cfg_pend_o),
    .err_o      (cfg_err_o)
  );

  always_ff @(posedge clk_in_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      p_act_q <= CNT_W'(P_DEF);
      s_act_q <= CNT_W'(S_DEF);
      n_act_q <= ratio_n(CNT_W'(P_DEF), CNT_W'(S_DEF));
      div_q   <= 1'b0;
    end else begin
      div_q <= wrap;
      if (en_i) begin
        pc_q <= wrap ? '0 : pc_q + CNT_W'(1);
      end
      if (apply) begin
        p_act_q <= p_sh;
        s_act_q <= s_sh;
        n_act_q <= ratio_n(p_sh, s_sh);
      end
    end
  end

`ifdef PSC_TOGGLE_OUT_EN
  logic tgl_q;
  always_ff @(posedge clk_in_i) begin
    if (rst_i) begin
      tgl_q <= 1'b0;
    end else if (wrap) begin
      tgl_q <= ~tgl_q;
    end
  end
  assign div_tgl_o = tgl_q;
`endif

  // The first S counts of each period use /4.
  assign mod_o     = (pc_q < s_act_q);
  assign div_out_o = div_q;
  assign n_act_o   = n_act_q;

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Bench for pulse_swallow_ctrl: directed scenarios followed by random traffic,
// all checked against a period-level reference model. The model also plays
// the prescaler, summing 4 or 3 input cycles per count from the observed mod
// and checking each completed period against 3P + S.
module tb_pulse_swallow_ctrl;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          ld;
  logic [CW-1:0] cp;
  logic [CW-1:0] cs;
  logic          mod;
  logic          dv;
  logic          pend;
  logic          err;
  logic [CW+1:0] n;
`ifdef PSC_TOGGLE_OUT_EN
  logic          tgl;
`endif

  always #5 clk = ~clk;

  pulse_swallow_ctrl #(
    .CNT_W (CW),
    .P_DEF (4),
    .S_DEF (0)
  ) dut (
    .clk_in_i   (clk),
    .rst_i      (rst),
    .en_i       (en),
    .cfg_load_i (ld),
    .cfg_p_i    (cp),
    .cfg_s_i    (cs),
    .mod_o      (mod),
    .div_out_o  (dv),
    .cfg_pend_o (pend),
    .cfg_err_o  (err),
`ifdef PSC_TOGGLE_OUT_EN
    .div_tgl_o  (tgl),
`endif
    .n_act_o    (n)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_pc, m_p, m_s, m_shp, m_shs, acc;
  bit m_pend, m_div, m_err, m_tgl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_p = 4; m_s = 0; m_shp = 4; m_shs = 0;
    m_pend = 0; m_div = 0; m_err = 0; m_tgl = 0; acc = 0;
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int p, input int s);
    bit pre_mod;
    bit valid;
    bit wrap;
    rst = r; en = e; ld = l;
    cp = p[CW-1:0];
    cs = s[CW-1:0];
    pre_mod = mod;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      valid = l && (p >= 1) && (s <= p);
      wrap  = e && (m_pc == m_p - 1);
      m_div = wrap;
      m_err = l && !valid;
      if (e) begin
        acc += pre_mod ? 4 : 3;
        if (wrap) begin
          chk("period_len", acc, 3 * m_p + m_s);
          acc = 0;
          m_tgl = !m_tgl;
        end
        m_pc = wrap ? 0 : m_pc + 1;
      end
      // A load on the boundary edge discards the older pending config.
      if (wrap && m_pend && !valid) begin
        m_p = m_shp; m_s = m_shs; m_pend = 0;
      end
      if (valid) begin
        m_shp = p; m_shs = s; m_pend = 1;
      end else if (wrap) begin
        m_pend = 0;
      end
    end
    #1;
    chk("mod", mod, (m_pc < m_s));
    chk("div_out", dv, m_div);
    chk("cfg_pend", pend, m_pend);
    chk("cfg_err", err, m_err);
    chk("n_act", n, 3 * m_p + m_s);
`ifdef PSC_TOGGLE_OUT_EN
    chk("div_tgl", tgl, m_tgl);
`endif
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 1, 0, 0, 0);
  endtask

  initial begin
    bit found;
    int div_cnt;
    model_reset();
    rst = 1; en = 0; ld = 0; cp = '0; cs = '0;

    // 1: reset values, then default N = 12 (mod low, div every 4).
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_n_act", n, 12);
    chk("rst_mod", mod, 0);
    chk("rst_div", dv, 0);
    div_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, 0);
      if (dv === 1'b1) div_cnt++;
    end
    chk("div_count_12cyc", div_cnt, 3);

    // 2: P=5 S=2 -> N=17.
    step(0, 1, 1, 5, 2);
    chk("pend_after_load", pend, 1);
    idle(16);
    chk("n17", n, 17);

    // 3: two loads before a wrap, only the last one is applied.
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_pc == 2) found = 1;
      else idle(1);
    end
    if (!found) begin
      checks++; errors++;
      $error("FAIL sync_pc2: observed timeout expected pc=2");
    end
    step(0, 1, 1, 7, 3);
    step(0, 1, 1, 6, 1);
    idle(14);
    chk("n19", n, 19);

    // 4: invalid loads rejected.
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 5, 6);
    chk("err_s_gt_p", err, 1);
    step(0, 1, 1, 0, 0);
    chk("err_p_zero", err, 1);
    idle(6);
    chk("n_after_err", n, 12);
    chk("pend_after_err", pend, 0);

    // 5: P=1 S=1 -> mod stuck high, div every cycle, then reset drops pending.
    step(0, 1, 1, 1, 1);
    idle(8);
    chk("p1_mod", mod, 1);
    chk("p1_div", dv, 1);
    chk("p1_n", n, 4);
    step(0, 1, 1, 2, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_pend_drop", pend, 0);
    chk("rst_n_again", n, 12);
    idle(8);

    // 6: enable dropped mid-period.
    step(0, 1, 1, 5, 2);
    idle(7);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    idle(12);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 9)),
           int'($urandom_range(0, 9)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_swallow_ctrl.md
Name: pulse_swallow_ctrl

Overview:
- Modulus controller for the dual-modulus divide-by-3/4 prescaler.
- Clocked by the prescaler output and drives its mod input. mod=1 selects ÷4; mod=0 selects ÷3.
- Counts P prescaler periods per output period and holds mod high for the first S of them. Total division ratio is N = 3·P + S, with 0 ≤ S ≤ P.
- Configuration is double-buffered and only takes effect on a period boundary, so no output period is ever truncated.

Parameters:
- CNT_W, 6, width of the P and S counters and of the config fields.
- P_DEF, 4, P value loaded at reset (must be ≥ 1).
- S_DEF, 0, S value loaded at reset (must be ≤ P_DEF). Default N = 12.

Ports:
- clk_in  input  1  prescaler output clock; the only clock of the block.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; when low, all state holds.
- cfg_load  input  1  one-cycle strobe that captures cfg_p and cfg_s.
- cfg_p  input  CNT_W  requested P.
- cfg_s  input  CNT_W  requested S.
- mod  output  1  modulus select to the prescaler (1 = ÷4).
- div_out  output  1  one-cycle pulse per completed output period.
- cfg_pend  output  1  accepted config is waiting for the next boundary.
- cfg_err  output  1  one-cycle pulse: load rejected.
- n_act  output  CNT_W+2  active ratio 3·p_act + s_act, registered.

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst. No other clock or async path.
- State registers:
  - pc_q (0..p_act−1)
  - p_act_q, s_act_q (active config)
  - p_sh_q, s_sh_q (shadow config)
  - pend_q
- Reset values:
  - pc_q = 0, p_act_q = P_DEF, s_act_q = S_DEF
  - pend_q = 0, div_out = 0, cfg_err = 0
  - n_act = 3·P_DEF + S_DEF
  - mod = (S_DEF > 0)
- mod = (pc_q < s_act_q). It is decoded from registered state only; no input feeds mod combinationally.
- Counting, on each edge with en = 1:
  - If pc_q == p_act_q−1 (wrap): pc_q ← 0 and div_out ← 1.
  - Otherwise: pc_q ← pc_q + 1 and div_out ← 0.
- div_out is therefore high during the cycle where pc_q == 0, except the first cycle after reset.
- en = 0:
  - pc_q, config and pend_q hold.
  - div_out ← 0.
  - mod keeps its decoded value.
  - cfg_load is still accepted into the shadow registers.
- Config load, when cfg_load = 1:
  - Valid means cfg_p ≥ 1 and cfg_s ≤ cfg_p.
  - Valid load: p_sh_q/s_sh_q ← cfg_p/cfg_s and pend_q ← 1.
  - Invalid load: cfg_err ← 1 for one cycle; shadow and pend_q are unchanged.
- Apply: on a wrap edge with pend_q = 1, the active config takes the shadow value and pend_q ← 0. n_act updates on the same edge.
- Load on the same edge as a wrap: the new load goes to the shadow and is applied at the following wrap. Any older pending value is discarded, never applied.
- Load while pending: the shadow is overwritten (last valid write wins) and pend_q stays 1.
- P = 1: every cycle is a wrap and div_out stays high continuously. S = 1 then gives mod = 1 permanently (N = 4).
- S = P: mod is high for the whole period (N = 4P). S = 0: mod is always low (N = 3P).
- Reset mid-period: all state returns to reset values on that edge and any pending config is lost.
- Arithmetic: n_act is computed at full width CNT_W+2. Width is sufficient since max = 4·(2^CNT_W − 1).

Optional Feature:
- Macro: PSC_TOGGLE_OUT_EN.
- Defined: adds output div_tgl, a register that resets to 0 and toggles on every wrap (≈50% duty, ratio 2N from the input of the prescaler). div_out is unchanged.
- Undefined: no div_tgl port and no extra flop.

Decomposition:
- Package pulse_swallow_pkg:
  - CNT_W default
  - function ratio_n(p, s) returning 3p+s at CNT_W+2 bits
  - function cfg_valid(p, s)
- One natural sub-module, ps_cfg_shadow: the shadow registers, the validity check, pend_q and cfg_err. It emits apply values to the top on a wrap strobe.
- Counter and mod decode stay in the top.

Test Plan:
1. Reset, en = 1, no load → mod = 0 always, div_out every 4 cycles, n_act = 12.
2. Load P = 5, S = 2 → cfg_pend = 1 until the next wrap. Then mod = 1,1,0,0,0 repeating, div_out period 5, n_act = 17. Prescaler+ctrl model measures ÷17.
3. Load P = 7, S = 3 at pc_q = 2, then load P = 6, S = 1 before the wrap → only 6/1 is applied, at the wrap. n_act = 19 and 7/3 is never observed.
4. Load P = 5, S = 6, then P = 0, S = 0 → cfg_err pulses twice and cfg_pend stays 0. Config unchanged, n_act = 12.
5. Load P = 1, S = 1 → after the boundary, mod is stuck at 1, div_out is high every cycle, n_act = 4. Then assert rst at an arbitrary cycle → all reset values next cycle and the pending config is dropped.
6. Drop en for 3 cycles mid-period → pc_q and mod frozen, no div_out. The period completes 3 cycles late with a correct count. With PSC_TOGGLE_OUT_EN defined, div_tgl toggles exactly at each div_out.
